// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save adder operand path.
package csa_pkg;

  // Default operand width, matching the three-operand carry-save adder.
  localparam int CSA_WIDTH = 32;

  // Slot indices: slot 0 feeds x, slot 1 feeds y, slot 2 feeds z.
  localparam logic [1:0] SLOT_X = 2'd0;
  localparam logic [1:0] SLOT_Y = 2'd1;
  localparam logic [1:0] SLOT_Z = 2'd2;

  // COLLECT gathers operands into slots.
  // HOLD presents a finished triple until the consumer takes it.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } coll_state_e;

endpackage

// File: rtl/csa_operand_collector.sv
// Packs a valid/ready operand stream into x/y/z triples for the carry-save adder.
// A stream "last" marker closes a short group early and zero-pads the unused slots,
// so any stream length sums correctly. The slot registers are the x/y/z outputs,
// which keeps every output registered or decoded from registered state.
module csa_operand_collector
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int GCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WIDTH-1:0]  x,
  output logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  z,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [GCNT_W-1:0] group_count
);

  coll_state_e        state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               last_q, last_d;
  logic [GCNT_W-1:0]  gcnt_q, gcnt_d;

  logic               accept;
  logic               group_close;
  logic               handoff;

  // Handshake qualifiers, all derived from registered state plus the inputs.
  always_comb begin
    accept      = (state_q == COLLECT) && in_valid;
    group_close = accept && ((slot_q == SLOT_Z) || in_last);
    handoff     = (state_q == HOLD) && out_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a closing accept enters HOLD, a handoff returns to COLLECT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (group_close) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Output decode: ready to collect and triple-valid are mutually exclusive.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      COLLECT: in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Slot write, padding on early close, clear and count on handoff.
  always_comb begin
    slot_d = slot_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    last_d = last_q;
    gcnt_d = gcnt_q;

    if (accept) begin
      unique case (slot_q)
        SLOT_X:  x_d = in_data;
        SLOT_Y:  y_d = in_data;
        default: z_d = in_data;
      endcase

      if (group_close) begin
        if (slot_q == SLOT_X) begin
          y_d = '0;
        end
        if (slot_q != SLOT_Z) begin
          z_d = '0;
        end
        last_d = in_last;
        slot_d = SLOT_X;
      end else begin
        slot_d = slot_q + 2'd1;
      end
    end

    if (handoff) begin
      x_d    = '0;
      y_d    = '0;
      z_d    = '0;
      last_d = 1'b0;
      gcnt_d = gcnt_q + GCNT_W'(1);
    end
  end

  // Datapath registers; reset discards any partial or held triple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_X;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      last_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      last_q <= last_d;
      gcnt_q <= gcnt_d;
    end
  end

  // Registered values drive the adder-facing outputs directly.
  always_comb begin
    x           = x_q;
    y           = y_q;
    z           = z_q;
    out_last    = last_q;
    group_count = gcnt_q;
  end

endmodule

// File: tb/tb_csa_operand_collector.sv
// Testbench for csa_operand_collector: directed scenarios plus a randomized
// stream checked against a transaction-level model of the grouping rules.
module tb_csa_operand_collector;

  localparam int W = 32;
  // A narrow counter keeps the wrap scenario short while exercising the same modulo rule.
  localparam int GW = 8;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W-1:0]  z;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic [GW-1:0] group_count;

  int n_checks;
  int n_pass;

  csa_operand_collector #(.WIDTH(W), .GCNT_W(GW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z           (z),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .group_count (group_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for exactly one edge; caller ensures in_ready is high.
  task automatic send_operand(input logic [W-1:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  // Asynchronous reset pulse released away from the clock edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Reset values before any clock edge has occurred.
  task automatic test_reset();
    #3;
    n_checks++;
    if ({x, y, z, out_valid, out_last, in_ready, group_count} !== {96'd0, 1'b0, 1'b0, 1'b1, {GW{1'b0}}})
      $display("[TB] FAIL reset_state: got x=%h y=%h z=%h ov=%b ol=%b ir=%b gc=%0d want all zero with ir=1",
               x, y, z, out_valid, out_last, in_ready, group_count);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
  endtask

  // 5, 7, 9 with last on 9 while out_ready is held high from the start.
  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_operand(32'd5, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("[TB] FAIL basic_early_ready: out_valid got %b want 0", out_valid);
    else n_pass++;
    send_operand(32'd7, 1'b0);
    send_operand(32'd9, 1'b1);
    n_checks++;
    if ({x, y, z, out_valid, out_last, in_ready} !== {32'd5, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0})
      $display("[TB] FAIL basic_triple: got %h %h %h ov=%b ol=%b ir=%b want 5 7 9 ov=1 ol=1 ir=0",
               x, y, z, out_valid, out_last, in_ready);
    else n_pass++;
    step();
    n_checks++;
    if ({x, y, z, out_valid, out_last, in_ready, group_count} !== {96'd0, 1'b0, 1'b0, 1'b1, GW'(1)})
      $display("[TB] FAIL basic_handoff: got %h %h %h ov=%b ol=%b ir=%b gc=%0d want zeros ir=1 gc=1",
               x, y, z, out_valid, out_last, in_ready, group_count);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  // Single all-ones operand closed by last: two slots of padding.
  task automatic test_single();
    do_reset();
    send_operand(32'hFFFF_FFFF, 1'b1);
    n_checks++;
    if ({x, y, z, out_valid, out_last} !== {32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b1})
      $display("[TB] FAIL single_pad: got %h %h %h ov=%b ol=%b want ffffffff 0 0 ov=1 ol=1",
               x, y, z, out_valid, out_last);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // 1..5 with last on 5: a full triple, then a one-slot-padded triple.
  task automatic test_five();
    do_reset();
    send_operand(32'd1, 1'b0);
    send_operand(32'd2, 1'b0);
    send_operand(32'd3, 1'b0);
    n_checks++;
    if ({x, y, z, out_valid, out_last} !== {32'd1, 32'd2, 32'd3, 1'b1, 1'b0})
      $display("[TB] FAIL five_first: got %h %h %h ov=%b ol=%b want 1 2 3 ov=1 ol=0",
               x, y, z, out_valid, out_last);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_operand(32'd4, 1'b0);
    send_operand(32'd5, 1'b1);
    n_checks++;
    if ({x, y, z, out_valid, out_last} !== {32'd4, 32'd5, 32'd0, 1'b1, 1'b1})
      $display("[TB] FAIL five_second: got %h %h %h ov=%b ol=%b want 4 5 0 ov=1 ol=1",
               x, y, z, out_valid, out_last);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (group_count !== GW'(2))
      $display("[TB] FAIL five_count: got %0d want 2", group_count);
    else n_pass++;
  endtask

  // Back-pressure: the held triple stays put and in_valid pulses are ignored.
  task automatic test_stall();
    int bad;
    do_reset();
    send_operand(32'd10, 1'b0);
    send_operand(32'd20, 1'b0);
    send_operand(32'd30, 1'b0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_last  = 1'(i % 2);
      if ({x, y, z, out_valid, in_ready} !== {32'd10, 32'd20, 32'd30, 1'b1, 1'b0}) bad++;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks++;
    if (bad != 0)
      $display("[TB] FAIL stall_hold: %0d of 6 cycles disturbed, want 0", bad);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, group_count} !== {1'b0, 1'b1, GW'(1)})
      $display("[TB] FAIL stall_handoff: got ov=%b ir=%b gc=%0d want ov=0 ir=1 gc=1",
               out_valid, in_ready, group_count);
    else n_pass++;
    send_operand(32'd99, 1'b1);
    n_checks++;
    if ({x, y, z, out_last} !== {32'd99, 32'd0, 32'd0, 1'b1})
      $display("[TB] FAIL stall_no_leak: got %h %h %h ol=%b want 63 0 0 ol=1", x, y, z, out_last);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Asynchronous reset mid-group discards the partial slots.
  task automatic test_reset_mid();
    do_reset();
    send_operand(32'd11, 1'b0);
    send_operand(32'd22, 1'b0);
    n_checks++;
    if ({x, y, out_valid} !== {32'd11, 32'd22, 1'b0})
      $display("[TB] FAIL midrst_partial: got %h %h ov=%b want b 16 ov=0", x, y, out_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({x, y, z, out_valid, out_last, in_ready, group_count} !== {96'd0, 1'b0, 1'b0, 1'b1, {GW{1'b0}}})
      $display("[TB] FAIL midrst_immediate: got %h %h %h ov=%b ol=%b ir=%b gc=%0d want zeros ir=1",
               x, y, z, out_valid, out_last, in_ready, group_count);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    send_operand(32'd3, 1'b0);
    send_operand(32'd4, 1'b0);
    send_operand(32'd5, 1'b1);
    n_checks++;
    if ({x, y, z, out_last} !== {32'd3, 32'd4, 32'd5, 1'b1})
      $display("[TB] FAIL midrst_fresh: got %h %h %h ol=%b want 3 4 5 ol=1", x, y, z, out_last);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (group_count !== GW'(1))
      $display("[TB] FAIL midrst_count: got %0d want 1", group_count);
    else n_pass++;
  endtask

  // 2^GW one-operand groups: the counter passes its maximum and wraps to zero.
  task automatic test_wrap();
    int total;
    total = 1 << GW;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= total; i++) begin
      send_operand($urandom, 1'b1);
      step();
      if (i == total - 1) begin
        n_checks++;
        if (group_count !== GW'(total - 1))
          $display("[TB] FAIL wrap_max: got %0d want %0d", group_count, total - 1);
        else n_pass++;
      end
    end
    n_checks++;
    if (group_count !== {GW{1'b0}})
      $display("[TB] FAIL wrap_zero: got %0d want 0", group_count);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  // Random stream with random gaps and back-pressure against a grouping model.
  task automatic test_random();
    localparam int N = 200;
    logic [W-1:0] ops[$];
    bit           lasts[$];
    bit           closes[$];
    logic [3*W:0] exp_q[$];
    logic [W-1:0] grp[$];
    logic [3*W:0] want;
    int idx, pending, handoffs, cycles, expected_groups;
    int bad_valid, bad_ready, bad_data;

    for (int i = 0; i < N; i++) begin
      ops.push_back($urandom);
      lasts.push_back(($urandom_range(0, 3) == 0) || (i == N - 1));
    end
    // Chunk the stream: a group ends after three operands or at a last marker.
    for (int i = 0; i < N; i++) begin
      grp.push_back(ops[i]);
      if (grp.size() == 3 || lasts[i]) begin
        while (grp.size() < 3) grp.push_back('0);
        exp_q.push_back({grp[0], grp[1], grp[2], 1'b1 & lasts[i]});
        grp.delete();
        closes.push_back(1'b1);
      end else begin
        closes.push_back(1'b0);
      end
    end
    expected_groups = exp_q.size();

    do_reset();
    idx = 0; pending = 0; handoffs = 0; cycles = 0;
    bad_valid = 0; bad_ready = 0; bad_data = 0;
    while ((idx < N || handoffs < expected_groups) && cycles < 5000) begin
      in_valid  = (idx < N) && ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? ops[idx] : $urandom;
      in_last   = in_valid ? lasts[idx] : 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid !== (pending > 0)) bad_valid++;
      if (in_ready !== (pending == 0)) bad_ready++;
      if (in_valid && in_ready === 1'b1) begin
        if (closes[idx]) pending++;
        idx++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          bad_data++;
        end else begin
          want = exp_q.pop_front();
          if ({x, y, z, out_last} !== want) begin
            bad_data++;
            if (bad_data <= 3)
              $display("[TB] FAIL random_triple: got %h %h %h ol=%b want %h", x, y, z, out_last, want);
          end
        end
        if (pending > 0) pending--;
        handoffs++;
      end
      step();
      cycles++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    n_checks++;
    if (cycles >= 5000)
      $display("[TB] FAIL random_timeout: used %0d cycles, handoffs %0d want %0d", cycles, handoffs, expected_groups);
    else n_pass++;
    n_checks++;
    if (bad_valid != 0)
      $display("[TB] FAIL random_out_valid: %0d bad cycles want 0", bad_valid);
    else n_pass++;
    n_checks++;
    if (bad_ready != 0)
      $display("[TB] FAIL random_in_ready: %0d bad cycles want 0", bad_ready);
    else n_pass++;
    n_checks++;
    if (bad_data != 0)
      $display("[TB] FAIL random_data: %0d bad triples want 0", bad_data);
    else n_pass++;
    n_checks++;
    if (group_count !== GW'(expected_groups))
      $display("[TB] FAIL random_count: got %0d want %0d", group_count, GW'(expected_groups));
    else n_pass++;
  endtask

  // Scenario sequence and summary.
  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    test_reset();
    test_basic();
    test_single();
    test_five();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_operand_collector.md
# csa_operand_collector

Upstream feeder for the 32-bit three-operand carry-save adder. Accepts a stream of operands, one per cycle on a valid/ready handshake, and packs them into triples. Each triple is presented on registered `x`/`y`/`z` outputs held stable for the adder. A stream `last` marker closes a short group early by zero-padding the unused slots, so streams of any length sum correctly.

## Interface
- `WIDTH`, 32, operand width; must match the adder's operand width.
- `GCNT_W`, 16, width of the emitted-group counter.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  WIDTH  incoming operand.
- `in_valid`  input  1  `in_data`/`in_last` valid.
- `in_last`  input  1  operand is the final one of its stream.
- `in_ready`  output  1  collector accepts an operand this cycle.
- `x`, `y`, `z`  output  WIDTH each  operand triple to the adder (slot 0, 1, 2).
- `out_valid`  output  1  triple on `x`/`y`/`z` is complete.
- `out_last`  output  1  triple contains the stream's final operand.
- `out_ready`  input  1  consumer takes the triple this cycle.
- `group_count`  output  GCNT_W  number of triples handed off since reset.

## Operation
- State machine with two states:
  - COLLECT: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Slot counter `slot` (0..2) selects the target register.
- COLLECT, accept (`in_valid`&&`in_ready`):
  - Write `in_data` into slot `slot`.
  - If `slot`==2 or `in_last`=1:
    - Zero every slot above `slot`.
    - Set `out_last`=`in_last`.
    - Set `slot`=0 and go to HOLD.
  - Otherwise `slot`++.
- COLLECT, no accept: all state holds.
- HOLD, `out_ready`=1:
  - Go to COLLECT.
  - `group_count`++, wrapping modulo 2^GCNT_W.
  - Clear `x`/`y`/`z`/`out_last` to 0.
- HOLD, `out_ready`=0: every output holds unchanged; no new input is taken.
- Sums are not computed here. Slot values pass bit-exact; zero padding is the only data modification.
- `in_last` on the third operand of a group closes that group normally; no extra padding.
- `in_data` is ignored unless accepted.
- `in_last` with `in_valid`=0 has no effect.

## Timing
- Reset values (asynchronous, immediate): state=COLLECT, `slot`=0, `x`=`y`=`z`=0, `out_valid`=0, `out_last`=0, `group_count`=0, `in_ready`=1.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: a group closes at accept edge N, and `out_valid` is high in the cycle after edge N.
- Handoff occurs at edge M, where M is the first edge with `out_ready`=1, so M≥N+1. At edge M, `out_valid` drops and `in_ready` rises.
- Peak throughput: one full triple per 4 cycles (3 accepts + 1 handoff).
- `out_ready` asserted early (before `out_valid`) has no effect.
- Reset mid-group discards partial slots. Reset during HOLD drops the triple without counting it.
- `group_count` wrap: 2^GCNT_W−1 → 0 on the next handoff.

## Structure
- Shared package `csa_pkg`:
  - State enum: COLLECT, HOLD.
  - Default `WIDTH` constant (32).
  - Slot index constants (0, 1, 2).
- Single flat module; no sub-module. Slot write-enable decode and padding logic stay inline.
- Intended top-level pairing: `x`/`y`/`z` of this block feed the adder's `x`/`y`/`z` directly.

## Test plan
- Stream of 5, 7, 9 (last on 9), `out_ready`=1 → one cycle after the third accept: `x`=5, `y`=7, `z`=9, `out_valid`=1, `out_last`=1. `group_count` reads 1 after handoff.
- Single operand 0xFFFF_FFFF with `in_last`=1 → `x`=0xFFFF_FFFF, `y`=0, `z`=0, `out_last`=1.
- Stream 1, 2, 3, 4, 5 (last on 5) → first triple (1,2,3) with `out_last`=0, then (4,5,0) with `out_last`=1. `group_count`=2.
- Triple 10, 20, 30 with `out_ready` held 0 for 6 cycles → `x`/`y`/`z` stable and `in_ready`=0 throughout. `in_valid` pulses are ignored. Handoff happens on the first `out_ready`=1 edge.
- Accept 11, 22, then assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Then stream 3, 4, 5 (last) → triple (3,4,5); `group_count`=1, with no stale 11/22.
- Drive 65 536 one-operand groups with `GCNT_W`=16 → `group_count` wraps to 0.
